// File: rtl/gf_div_seq.sv
// Sequential GF(2^8) divider: q = a * b^254, one exponent bit per cycle,
// then a final multiply by a. The reduction polynomial's low byte is programmable.
module gf_div_seq #(
   parameter logic [7:0] EXP = 8'b11111110
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] p,
   output logic [7:0] q,
   output logic       busy,
   output logic       done,
   output logic       div_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_EXP, ST_MUL, ST_DONE} state_t;

   state_t     state, state_n;
   logic [7:0] a_r, b_r, p_r, r;
   logic [7:0] a_n, b_n, p_n, r_n, q_n;
   logic [2:0] cnt, cnt_n;
   logic       busy_n, done_n, err_n;
   logic [7:0] rr, rrb, ar;

   // Shift-and-add field multiply; x^8 is implied above the low byte in poly.
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y,
                                         input logic [7:0] poly);
      logic [7:0] acc;
      logic [7:0] t;
      acc = 8'h00;
      t   = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) acc = acc ^ t;
         t = t[7] ? ({t[6:0], 1'b0} ^ poly) : {t[6:0], 1'b0};
      end
      return acc;
   endfunction

   assign rr  = gf_mul(r, r, p_r);
   assign rrb = gf_mul(rr, b_r, p_r);
   assign ar  = gf_mul(a_r, r, p_r);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         a_r     <= 8'h00;
         b_r     <= 8'h00;
         p_r     <= 8'h00;
         r       <= 8'h01;
         cnt     <= 3'd7;
         q       <= 8'h00;
         busy    <= 1'b0;
         done    <= 1'b0;
         div_err <= 1'b0;
      end else begin
         state   <= state_n;
         a_r     <= a_n;
         b_r     <= b_n;
         p_r     <= p_n;
         r       <= r_n;
         cnt     <= cnt_n;
         q       <= q_n;
         busy    <= busy_n;
         done    <= done_n;
         div_err <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      a_n     = a_r;
      b_n     = b_r;
      p_n     = p_r;
      r_n     = r;
      cnt_n   = cnt;
      q_n     = q;
      busy_n  = busy;
      done_n  = 1'b0;
      err_n   = div_err;

      case (state)
         ST_IDLE: begin
            if (start) begin
               a_n   = a;
               b_n   = b;
               p_n   = p;
               err_n = 1'b0;
               if (b == 8'h00) begin
                  // No inverse exists: report immediately without going busy.
                  q_n     = 8'h00;
                  err_n   = 1'b1;
                  done_n  = 1'b1;
                  state_n = ST_DONE;
               end else begin
                  r_n     = 8'h01;
                  cnt_n   = 3'd7;
                  busy_n  = 1'b1;
                  state_n = ST_EXP;
               end
            end
         end
         ST_EXP: begin
            // Exponent scanned MSB first: square, then multiply by b on a 1 bit.
            r_n   = EXP[cnt] ? rrb : rr;
            cnt_n = cnt - 3'd1;
            if (cnt == 3'd0) state_n = ST_MUL;
         end
         ST_MUL: begin
            q_n     = ar;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = ST_DONE;
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_gf_div_seq.sv
// Bench for gf_div_seq: directed vector table, multi-cycle corner sequences,
// random operations and a full inverse sweep against a polynomial-arithmetic model.
module tb_gf_div_seq;

   logic       clk, rst, start;
   logic [7:0] a, b, p, q;
   logic       busy, done, div_err;

   int n_pass  = 0;
   int n_total = 0;

   gf_div_seq dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .p(p),
      .q(q), .busy(busy), .done(done), .div_err(div_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] p;
      logic [7:0] q;
      logic       err;
   } vec_t;

   vec_t vecs[7];

   // Carry-less product followed by long division by x^8 + p.
   function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                          input logic [7:0] poly);
      logic [15:0] prod;
      logic [15:0] m;
      prod = 16'h0000;
      m    = 16'({1'b1, poly});
      for (int i = 0; i < 8; i++)
         if (y[i]) prod = prod ^ (16'(x) << i);
      for (int k = 14; k >= 8; k--)
         if (prod[k]) prod = prod ^ (m << (k - 8));
      return prod[7:0];
   endfunction

   // Quotient by definition: a times b raised to 254 by plain repeated product.
   function automatic logic [7:0] ref_div(input logic [7:0] x, input logic [7:0] y,
                                          input logic [7:0] poly);
      logic [7:0] pw;
      if (y == 8'h00) return 8'h00;
      pw = 8'h01;
      for (int i = 0; i < 254; i++) pw = ref_mul(pw, y, poly);
      return ref_mul(x, pw, poly);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // One full operation; inputs are scrambled after acceptance to prove latching.
   task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ip,
                        output logic [7:0] oq, output logic oerr,
                        output int lat, output int nbusy, output int ndone);
      @(negedge clk);
      a = ia; b = ib; p = ip; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); p = 8'($urandom);
      lat   = 0;
      nbusy = busy ? 1 : 0;
      ndone = done ? 1 : 0;
      while (!done && lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) nbusy++;
         if (done) ndone++;
      end
      oq   = q;
      oerr = div_err;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (busy) nbusy++;
         if (done) ndone++;
      end
   endtask

   initial begin
      logic [7:0] rq, ra, rb, rp;
      logic       rerr;
      int         lat, nbusy, ndone, d1, d2, cyc;

      vecs[0] = '{a: 8'h01, b: 8'h53, p: 8'h1B, q: 8'hCA, err: 1'b0};
      vecs[1] = '{a: 8'hC1, b: 8'h83, p: 8'h1B, q: 8'h57, err: 1'b0};
      vecs[2] = '{a: 8'h57, b: 8'h01, p: 8'h1B, q: 8'h57, err: 1'b0};
      vecs[3] = '{a: 8'hD7, b: 8'h00, p: 8'h1B, q: 8'h00, err: 1'b1};
      vecs[4] = '{a: 8'h01, b: 8'h53, p: 8'h1B, q: 8'hCA, err: 1'b0};
      vecs[5] = '{a: 8'h00, b: 8'h53, p: 8'h1B, q: 8'h00, err: 1'b0};
      vecs[6] = '{a: 8'h01, b: 8'h02, p: 8'h1B, q: 8'h8D, err: 1'b0};

      rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; p = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_q", 32'(q), 32'h00);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_err", 32'(div_err), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table, including divide-by-zero followed by an error-clearing op.
      for (int i = 0; i < 7; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].p, rq, rerr, lat, nbusy, ndone);
         chk($sformatf("vec%0d_q", i), 32'(rq), 32'(vecs[i].q));
         chk($sformatf("vec%0d_err", i), 32'(rerr), 32'(vecs[i].err));
         chk($sformatf("vec%0d_lat", i), 32'(lat), vecs[i].err ? 32'd0 : 32'd9);
         chk($sformatf("vec%0d_busy", i), 32'(nbusy), vecs[i].err ? 32'd0 : 32'd9);
         chk($sformatf("vec%0d_ndone", i), 32'(ndone), 32'd1);
      end

      // Second start while busy must be ignored.
      @(negedge clk);
      a = 8'h01; b = 8'h53; p = 8'h1B; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      b = 8'h02; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      ndone = 0;
      rq    = 8'hFF;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            rq = q;
         end
      end
      chk("ignore_q", 32'(rq), 32'hCA);
      chk("ignore_ndone", 32'(ndone), 32'd1);

      // Reset in the middle of an exponentiation aborts without a done.
      @(negedge clk);
      a = 8'hC1; b = 8'h83; p = 8'h1B; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_q", 32'(q), 32'h00);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_done", 32'(done), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      chk("abort_nodone", 32'(ndone), 32'd0);
      do_op(8'hC1, 8'h83, 8'h1B, rq, rerr, lat, nbusy, ndone);
      chk("restart_q", 32'(rq), 32'h57);
      chk("restart_lat", 32'(lat), 32'd9);

      // start held high: back-to-back operations every 11 cycles.
      @(negedge clk);
      a = 8'h01; b = 8'h53; p = 8'h1B; start = 1'b1;
      d1 = 0; d2 = 0; cyc = 0;
      while (d2 == 0 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) begin
            if (d1 == 0) d1 = cyc;
            else begin
               d2 = cyc;
               start = 1'b0;
               chk("held_q", 32'(q), 32'hCA);
            end
         end
      end
      start = 1'b0;
      chk("held_first_lat", 32'(d1), 32'd10);
      chk("held_spacing", 32'(d2 - d1), 32'd11);
      repeat (12) @(posedge clk);

      // Random operands and polynomials against the model.
      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = (i % 8 == 0) ? 8'h00 : 8'($urandom);
         rp = 8'($urandom);
         do_op(ra, rb, rp, rq, rerr, lat, nbusy, ndone);
         chk($sformatf("rand%0d_q a=%0h b=%0h p=%0h", i, ra, rb, rp), 32'(rq),
             32'(ref_div(ra, rb, rp)));
         chk($sformatf("rand%0d_err", i), 32'(rerr), (rb == 8'h00) ? 32'h1 : 32'h0);
      end

      // Full inverse sweep over the AES field.
      for (int i = 1; i < 256; i++) begin
         rb = 8'(i);
         do_op(8'h01, rb, 8'h1B, rq, rerr, lat, nbusy, ndone);
         chk($sformatf("inv_b%0h", rb), 32'(rq), 32'(ref_div(8'h01, rb, 8'h1B)));
         chk($sformatf("inv_prod_b%0h", rb), 32'(ref_mul(rb, rq, 8'h1B)), 32'h01);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gf_div_seq.md
Name: gf_div_seq

Overview:
- Sequential GF(2^8) divider: q = a / b = a · b^-1, with a programmable reduction polynomial.
- The inverse is computed as b^254 by square-and-multiply, one exponent bit per cycle, followed by one multiply by a.
- It is the companion to the combinational inverse block: it consumes a divisor and undoes a prior GF multiply.
- It is used by the field-arithmetic datapath and by self-checks of the multiplier/inverse blocks.

Parameters:
- EXP, 8'b11111110 (254), inversion exponent 2^8-2. Fixed for GF(2^8); exposed only for checking.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only when busy=0
- a  input  8  dividend
- b  input  8  divisor
- p  input  8  low byte of reduction polynomial (x^8 implied; 8'h1B gives the AES polynomial)
- q  output  8  quotient; held from done until the next accepted start
- busy  output  1  high from the accepting edge until the edge before done
- done  output  1  one-cycle registered pulse when q is valid
- div_err  output  1  set with done when b==0; cleared on the next accepted start

Behaviour:
- Reset (async, any state): state=IDLE, q=0, busy=0, done=0, div_err=0, internal accumulator r=1, bit counter=7.
- GF multiply is combinational, inside the block:
  - shift-and-add over 8 bits;
  - on each left shift with MSB out =1, XOR with p;
  - addition is XOR.
- States: IDLE, EXP, MUL, DONE.
- IDLE:
  - done=0.
  - On start=1 at edge T: latch a, b, p into registers, clear div_err.
  - If latched b==0: go to DONE with q=0, div_err=1, done=1 after edge T (latency 1); busy stays 0.
  - Else: r=1, cnt=7, busy=1, go to EXP.
- EXP (edges T+1..T+8, bit i = cnt):
  - r <= EXP[i] ? (r·r)·b : r·r.
  - cnt decrements; at cnt==0 go to MUL.
  - The exponent runs MSB first.
- MUL (edge T+9): q <= a·r, done <= 1, busy <= 0, go to DONE.
- DONE: next edge done <= 0, go to IDLE. start is not accepted in DONE.
- Latency: start at edge T gives done high during the cycle after edge T+9 (9-cycle latency).
  - Minimum start-to-start spacing is 11 cycles (accept at T, done after T+9, back in IDLE after T+10, next accept at T+11).
- Inputs a, b, p may change freely after acceptance; the latched copies are used.
- start while busy=1 or in DONE: ignored, with no effect on the in-flight operation.
- a==0, b!=0: full 9-cycle sequence; q=0, div_err=0.
- b==1: q=a.
- Reset asserted mid-EXP/MUL: immediate return to IDLE with all outputs zero. No done is produced for the aborted operation.
- start held high continuously: a new operation is accepted every time the block is in IDLE.

Test Plan:
1. rst=1 then release; a=8'h01, b=8'h53, p=8'h1B, start pulse -> done after 9 cycles, q=8'hCA, div_err=0, busy high exactly 9 cycles.
2. a=8'hC1, b=8'h83, p=8'h1B -> q=8'h57. Then a=8'h57, b=8'h01 -> q=8'h57.
3. a=8'hD7, b=8'h00 -> done one cycle after start, q=8'h00, div_err=1, busy never high. A following valid start clears div_err.
4. Accept a=8'h01, b=8'h53; pulse start again at cycle 4 with b=8'h02 -> second start ignored, result q=8'hCA, one done only.
5. Accept an operation; assert rst at cycle 5 -> q=0, busy=0, done=0 immediately, no done pulse afterwards. A restart gives the correct result.
6. Sweep b=1..255 with a=8'h01, p=8'h1B; compare q against a bench inverse model, and check that a·q==8'h01 for every b.
